// File: rtl/resp_sig_capture.sv
// Response-side MISR capture: folds dut_out into per-frame signatures, streams records.
// Optional RESP_SIG_PARITY_EN adds out_par, the XOR-reduce of out_data.
module resp_sig_capture #(
  parameter int          OUT_W      = 330,
  parameter int          FRAME_LEN  = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] POLY       = 32'h04C11DB7,
  parameter logic [31:0] SEED       = 32'hFFFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [OUT_W-1:0] dut_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             overflow,
  output logic [15:0]      frame_cnt,
  output logic             busy
`ifdef RESP_SIG_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int NS = (OUT_W + 31) / 32;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST_N = 16'(FRAME_LEN - 1);
  localparam logic [15:0] NSAMP  = 16'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [15:0] idx;
    logic [15:0] nsamp;
    logic [31:0] sig;
  } rec_t;

  state_t state, state_d;
  logic [31:0] sig, sig_d, sig_next, fold;
  logic [15:0] n, n_d;
  logic [NS*32-1:0] padded;
  logic gen, push, pop, xfer, full, empty, beat;
  rec_t rec, head;
  rec_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  always_comb begin
    padded = '0;
    padded[OUT_W-1:0] = dut_out;
    fold = '0;
    for (int k = 0; k < NS; k++) begin
      fold = fold ^ padded[32*k +: 32];
    end
  end

  assign sig_next = {sig[30:0], 1'b0}
                  ^ (sig[31] ? POLY : 32'h0)
                  ^ fold;

  always_comb begin
    state_d = state;
    sig_d   = sig;
    n_d     = n;
    gen     = 1'b0;
    rec     = '0;
    unique case (state)
      IDLE: begin
        if (cap_en) state_d = RUN;
      end
      RUN: begin
        if (cap_en) begin
          if (n == LAST_N) begin
            gen   = 1'b1;
            rec   = {frame_cnt, NSAMP, sig_next};
            sig_d = SEED;
            n_d   = '0;
          end else begin
            sig_d = sig_next;
            n_d   = n + 16'd1;
          end
        end else begin
          state_d = (n != 16'd0) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        gen     = 1'b1;
        rec     = {frame_cnt, n, sig};
        sig_d   = SEED;
        n_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Full is judged on the pre-pop occupancy
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = gen && !full;
  assign xfer  = out_valid && out_ready;
  assign pop   = xfer && beat;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sig       <= SEED;
      n         <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      beat      <= 1'b0;
    end else begin
      state <= state_d;
      sig   <= sig_d;
      n     <= n_d;
      if (gen) frame_cnt <= frame_cnt + 16'd1;
      if (gen && full) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (xfer) beat <= ~beat;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rec;
  end

  assign out_valid = !empty;
  assign out_last  = !empty && beat;
  assign out_data  = empty ? 32'h0
                   : beat  ? head.sig
                   : {head.idx, head.nsamp};
  assign busy      = (state != IDLE) || !empty;

`ifdef RESP_SIG_PARITY_EN
  assign out_par = ^out_data;
`endif

endmodule
